// File: rtl/sw_pkg.sv
// Shared widths, digit limits and default time base for the stopwatch time counter.
package sw_pkg;

    localparam int BCD_W  = 4;
    localparam int SECT_W = 3;

    localparam int TENTHS_MAX   = 9;
    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_ONES_MAX = 9;

    localparam int DEFAULT_TICKS_PER_TENTH = 10_000_000;

    // Total number of distinct displayed times, 0:00.0 .. 9:59.9.
    function automatic int time_span();
        return (TENTHS_MAX + 1) * (SEC_ONES_MAX + 1) * (SEC_TENS_MAX + 1) * (MIN_ONES_MAX + 1);
    endfunction

endpackage

// File: rtl/sw_bcd_digit.sv
// One wrapping counter digit of the stopwatch chain; values above MAX fold to 0 on the next advance.
module sw_bcd_digit #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc_in,
    output logic [W-1:0] q,
    output logic         carry_out
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] q_r;
    logic [W-1:0] q_nxt_s;

    // Next digit value: clear, advance with rollover, or hold.
    always_comb begin
        q_nxt_s = q_r;
        if (clr) begin
            q_nxt_s = '0;
        end else if (inc_in) begin
            if (q_r >= MAX_V) begin
                q_nxt_s = '0;
            end else begin
                q_nxt_s = q_r + W'(1);
            end
        end else begin
            q_nxt_s = q_r;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
        end else begin
            q_r <= q_nxt_s;
        end
    end

    assign q         = q_r;
    assign carry_out = inc_in & (q_r == MAX_V);

endmodule

// File: rtl/sw_time_counter.sv
// Stopwatch time base: prescales clk to 0.1 s advances and counts M:SS.t in a four-digit chain.
module sw_time_counter
    import sw_pkg::*;
#(
    parameter int TICKS_PER_TENTH = DEFAULT_TICKS_PER_TENTH,
    parameter int PRESC_W         = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_regs,
    input  logic              count_enabled,
    output logic [BCD_W-1:0]  tenths,
    output logic [BCD_W-1:0]  sec_ones,
    output logic [SECT_W-1:0] sec_tens,
    output logic [BCD_W-1:0]  min_ones,
    output logic              tick,
    output logic              wrap
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_TENTH - 1);

    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_nxt_s;
    logic               tick_r;
    logic               wrap_r;
    logic               at_last_s;
    logic               advance_s;
    logic               c_tenths_s;
    logic               c_sec_ones_s;
    logic               c_sec_tens_s;
    logic               c_min_ones_s;

    // A corrupted prescaler beyond the last count is treated as a terminal count.
    assign at_last_s = (presc_r >= PRESC_LAST);
    assign advance_s = count_enabled & ~init_regs & at_last_s;

    // Prescaler next value: clear beats run beats hold.
    always_comb begin
        presc_nxt_s = presc_r;
        if (init_regs) begin
            presc_nxt_s = '0;
        end else if (count_enabled) begin
            if (at_last_s) begin
                presc_nxt_s = '0;
            end else begin
                presc_nxt_s = presc_r + PRESC_W'(1);
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Prescaler and tick/wrap pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            presc_r <= presc_nxt_s;
            tick_r  <= advance_s;
            wrap_r  <= c_min_ones_s;
        end
    end

    sw_bcd_digit #(.MAX(TENTHS_MAX), .W(BCD_W)) u_tenths (
        .clk       (clk),
        .reset     (reset),
        .clr       (init_regs),
        .inc_in    (advance_s),
        .q         (tenths),
        .carry_out (c_tenths_s)
    );

    sw_bcd_digit #(.MAX(SEC_ONES_MAX), .W(BCD_W)) u_sec_ones (
        .clk       (clk),
        .reset     (reset),
        .clr       (init_regs),
        .inc_in    (c_tenths_s),
        .q         (sec_ones),
        .carry_out (c_sec_ones_s)
    );

    sw_bcd_digit #(.MAX(SEC_TENS_MAX), .W(SECT_W)) u_sec_tens (
        .clk       (clk),
        .reset     (reset),
        .clr       (init_regs),
        .inc_in    (c_sec_ones_s),
        .q         (sec_tens),
        .carry_out (c_sec_tens_s)
    );

    // The minutes carry fires only from 9:59.9, so it doubles as the wrap event.
    sw_bcd_digit #(.MAX(MIN_ONES_MAX), .W(BCD_W)) u_min_ones (
        .clk       (clk),
        .reset     (reset),
        .clr       (init_regs),
        .inc_in    (c_sec_tens_s),
        .q         (min_ones),
        .carry_out (c_min_ones_s)
    );

    assign tick = tick_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_sw_time_counter.sv
// Self-checking bench for sw_time_counter against an elapsed-tenths reference model.
module tb_sw_time_counter;

    localparam int T       = 4;
    localparam int PW      = 3;
    localparam int SPAN    = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_regs = 1'b0;
    logic       count_enabled = 1'b0;
    logic [3:0] tenths;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic       tick;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: cycles into the current tenth plus total elapsed tenths.
    int m_presc = 0;
    int m_t     = 0;
    logic m_tick = 1'b0;
    logic m_wrap = 1'b0;

    int ticks_seen = 0;
    int wraps_seen = 0;

    sw_time_counter #(.TICKS_PER_TENTH(T), .PRESC_W(PW)) dut (
        .clk           (clk),
        .reset         (reset),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .tenths        (tenths),
        .sec_ones      (sec_ones),
        .sec_tens      (sec_tens),
        .min_ones      (min_ones),
        .tick          (tick),
        .wrap          (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] time_of(input int t);
        logic [3:0] mo, so, te;
        logic [2:0] st;
        mo = 4'((t / 600) % 10);
        st = 3'((t / 100) % 6);
        so = 4'((t / 10) % 10);
        te = 4'(t % 10);
        return {17'd0, mo, st, so, te};
    endfunction

    function automatic logic [31:0] dut_time();
        return {17'd0, min_ones, sec_tens, sec_ones, tenths};
    endfunction

    task automatic step(input logic r, input logic i, input logic e);
        reset = r;
        init_regs = i;
        count_enabled = e;
        @(posedge clk);
        if (r || i) begin
            m_presc = 0; m_t = 0; m_tick = 1'b0; m_wrap = 1'b0;
        end else if (e) begin
            if (m_presc == T - 1) begin
                m_presc = 0;
                m_tick  = 1'b1;
                m_wrap  = (m_t == SPAN - 1);
                m_t     = (m_t + 1) % SPAN;
            end else begin
                m_presc = m_presc + 1;
                m_tick  = 1'b0;
                m_wrap  = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
            m_wrap = 1'b0;
        end
        #1;
        if (tick === 1'b1) ticks_seen++;
        if (wrap === 1'b1) wraps_seen++;
        check("cycle", {dut_time()[14:0], tick, wrap}, {time_of(m_t)[14:0], m_tick, m_wrap});
    endtask

    initial begin
        logic [31:0] held;
        int tick_idx;
        int state;

        // 1: reset then first tenth
        step(1'b1, 1'b0, 1'b0);
        check("reset_digits", dut_time(), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("reset_pulses", {30'd0, tick, wrap}, 32'd0);
        ticks_seen = 0;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
        check("t1_ticks", ticks_seen, 32'd1);
        check("t1_tenths", {28'd0, tenths}, 32'd1);

        // 2: forty cycles, ten ticks, carry into seconds
        ticks_seen = 0;
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b1);
        check("t2_ticks", ticks_seen, 32'd10);
        check("t2_time", dut_time(), time_of(11));

        // 3: pause mid-tenth
        tick_idx = -1;
        held = 32'd0;
        for (int k = 0; k < 11; k++) begin
            step(1'b0, 1'b0, (k < 2) || (k > 8));
            if (k == 1) held = dut_time();
            if (k > 1 && k < 9) check("t3_frozen", dut_time(), held);
            if (tick === 1'b1) tick_idx = k;
        end
        check("t3_tick_idx", tick_idx, 32'd10);
        check("t3_time", dut_time(), time_of(12));

        // 4: run to 9:59.9 then roll over
        step(1'b0, 1'b1, 1'b0);
        wraps_seen = 0;
        for (int k = 0; k < (SPAN - 1) * T; k++) step(1'b0, 1'b0, 1'b1);
        check("t4_max", dut_time(), {17'd0, 4'd9, 3'd5, 4'd9, 4'd9});
        check("t4_nowrap", wraps_seen, 32'd0);
        for (int k = 0; k < T; k++) step(1'b0, 1'b0, 1'b1);
        check("t4_zero", dut_time(), 32'd0);
        check("t4_pulses", {30'd0, tick, wrap}, 32'd3);
        step(1'b0, 1'b0, 1'b1);
        check("t4_wrap_once", {31'd0, wrap}, 32'd0);
        check("t4_wraps", wraps_seen, 32'd1);

        // 5: clear at 0:12.3 with a tick pending
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 123 * T + T - 1; k++) step(1'b0, 1'b0, 1'b1);
        check("t5_pre", dut_time(), time_of(123));
        step(1'b0, 1'b1, 1'b1);
        check("t5_digits", dut_time(), 32'd0);
        check("t5_presc", {29'd0, dut.presc_r}, 32'd0);
        check("t5_tick", {31'd0, tick}, 32'd0);

        // 6: Ctl-like IDLE / COUNTING / PAUSED walk
        state = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) state = $urandom_range(0, 2);
            if ($urandom_range(0, 499) == 0) begin
                step(1'b1, 1'b0, 1'b0);
            end else begin
                step(1'b0, state == 0, state == 1);
                if (state == 0) check("t6_idle", dut_time(), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
